// File: rtl/pia_bridge.sv
// Apple-1 PIA register view (KBD/KBDCR/DSP/DSPCR) bridging CPU accesses to an
// inbound keyboard FIFO and an outbound valid/ready display stream.
module pia_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter bit UPCASE     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] address,
    input  logic       w_en,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       dsp_overrun
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [6:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [6:0]    last_key_r;
    logic [6:0]    kbd_ctrl_r;
    logic [7:0]    dsp_ctrl_r;

    logic empty_s;
    logic full_s;
    logic push_s;
    logic pop_s;
    logic kbdcr_wr_s;
    logic dsp_wr_s;
    logic dspcr_wr_s;
    logic retire_s;
    logic [6:0] head_s;

    // Keyboard byte normalisation applied on the way into the FIFO.
    function automatic logic [6:0] map_key(input logic [7:0] b);
        logic [6:0] k;
        if (UPCASE && (b >= 8'h61) && (b <= 8'h7A)) begin
            k = b[6:0] - 7'h20;
        end else if (UPCASE && (b == 8'h0A)) begin
            k = 7'h0D;
        end else begin
            k = b[6:0];
        end
        return k;
    endfunction

    assign empty_s    = (count_r == '0);
    assign full_s     = (count_r == CNT_FULL);
    assign rx_ready   = ~full_s;
    assign push_s     = rx_valid & ~full_s;
    assign pop_s      = enable & ~w_en & (address == 2'd0) & ~empty_s;
    assign kbdcr_wr_s = enable & w_en & (address == 2'd1);
    assign dsp_wr_s   = enable & w_en & (address == 2'd2);
    assign dspcr_wr_s = enable & w_en & (address == 2'd3);
    assign retire_s   = tx_valid & tx_ready;
    assign head_s     = empty_s ? last_key_r : mem_r[rd_ptr_r];

    // Register read mux; KBD falls back to the last popped key when empty.
    always_comb begin
        dout = 8'h00;
        case (address)
            2'd0:    dout = {1'b1, head_s};
            2'd1:    dout = {~empty_s, kbd_ctrl_r};
            2'd2:    dout = {tx_valid, 7'b0000000};
            2'd3:    dout = dsp_ctrl_r;
            default: dout = 8'h00;
        endcase
    end

    // Keyboard FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 7'h00;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            last_key_r <= 7'h00;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= map_key(rx_data);
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                last_key_r <= mem_r[rd_ptr_r];
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Control registers and the sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbd_ctrl_r  <= 7'h00;
            dsp_ctrl_r  <= 8'h00;
            dsp_overrun <= 1'b0;
        end else begin
            if (kbdcr_wr_s) begin
                kbd_ctrl_r <= din[6:0];
            end
            if (dspcr_wr_s) begin
                dsp_ctrl_r  <= din;
                dsp_overrun <= 1'b0;
            end else if (dsp_wr_s && tx_valid && !tx_ready) begin
                dsp_overrun <= 1'b1;
            end
        end
    end

    // Display holding register; a write may replace a byte retiring this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (dsp_wr_s && (!tx_valid || tx_ready)) begin
            tx_data  <= {1'b0, din[6:0]};
            tx_valid <= 1'b1;
        end else if (retire_s) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pia_bridge.sv
// Directed self-checking bench for pia_bridge with default parameters
// (FIFO_DEPTH=4, UPCASE=1).
module tb_pia_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] address;
    logic       w_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       dsp_overrun;

    int passed = 0;
    int total  = 0;

    pia_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .address     (address),
        .w_en        (w_en),
        .din         (din),
        .dout        (dout),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .dsp_overrun (dsp_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Read access: dout sampled before the edge that performs any pop.
    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
        enable  = 1'b1;
        w_en    = 1'b0;
        address = a;
        #1;
        chk(tag, dout, exp);
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        enable  = 1'b1;
        w_en    = 1'b1;
        address = a;
        din     = d;
        @(posedge clk);
        #1;
        enable = 1'b0;
        w_en   = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        address  = 2'd0;
        w_en     = 1'b0;
        din      = 8'h00;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
        chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_overrun", {7'd0, dsp_overrun}, 8'h00);
        rd(2'd1, 8'h00, "rst_kbdcr");
        rd(2'd0, 8'h80, "rst_kbd");
        rd(2'd3, 8'h00, "rst_dspcr");

        // Key path with upcase and LF->CR mapping
        push(8'h61);
        push(8'h0A);
        rd(2'd1, 8'h80, "kbdcr_nonempty");
        rd(2'd0, 8'hC1, "kbd_a_upcased");
        rd(2'd0, 8'h8D, "kbd_lf_to_cr");
        rd(2'd1, 8'h00, "kbdcr_empty");
        rd(2'd0, 8'h8D, "kbd_last_key");
        rd(2'd0, 8'h8D, "kbd_last_key_again");

        // Mapping range boundaries and bit7 drop
        push(8'h60);
        push(8'h7A);
        push(8'h7B);
        push(8'hB1);
        rd(2'd0, 8'hE0, "map_below_range");
        rd(2'd0, 8'hDA, "map_z_upper_edge");
        rd(2'd0, 8'hFB, "map_above_range");
        rd(2'd0, 8'hB1, "bit7_dropped");

        // FIFO fill with rx_valid held high
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'h31 + 8'(i);
            @(posedge clk);
            #1;
        end
        rx_data = 8'h35;
        chk("full_rx_ready", {7'd0, rx_ready}, 8'h00);
        @(posedge clk);
        #1;
        chk("full_hold_rx_ready", {7'd0, rx_ready}, 8'h00);
        rd(2'd0, 8'hB1, "full_pop_b1");
        chk("after_pop_rx_ready", {7'd0, rx_ready}, 8'h01);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("refill_rx_ready", {7'd0, rx_ready}, 8'h00);
        rd(2'd0, 8'hB2, "fifo_b2");
        rd(2'd0, 8'hB3, "fifo_b3");
        rd(2'd0, 8'hB4, "fifo_b4");
        rd(2'd0, 8'hB5, "fifo_b5");
        rd(2'd1, 8'h00, "fifo_drained");

        // KBDCR bit7 is not writable
        wr(2'd1, 8'hFF);
        rd(2'd1, 8'h7F, "kbdcr_write");

        // Display handshake and overrun
        tx_ready = 1'b0;
        wr(2'd2, 8'hC8);
        chk("dsp_tx_valid", {7'd0, tx_valid}, 8'h01);
        chk("dsp_tx_data", tx_data, 8'h48);
        rd(2'd2, 8'h80, "dsp_busy");
        wr(2'd2, 8'h49);
        chk("drop_tx_data", tx_data, 8'h48);
        chk("drop_overrun", {7'd0, dsp_overrun}, 8'h01);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        chk("retire_tx_valid", {7'd0, tx_valid}, 8'h00);
        rd(2'd2, 8'h00, "dsp_idle");
        chk("overrun_sticky", {7'd0, dsp_overrun}, 8'h01);
        wr(2'd3, 8'hA7);
        chk("dspcr_clr_overrun", {7'd0, dsp_overrun}, 8'h00);
        rd(2'd3, 8'hA7, "dspcr_read");

        // DSP write coincident with retire
        wr(2'd2, 8'h41);
        chk("b2b_first_data", tx_data, 8'h41);
        tx_ready = 1'b1;
        wr(2'd2, 8'h5A);
        chk("b2b_tx_valid", {7'd0, tx_valid}, 8'h01);
        chk("b2b_tx_data", tx_data, 8'h5A);
        chk("b2b_no_overrun", {7'd0, dsp_overrun}, 8'h00);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        chk("b2b_retired", {7'd0, tx_valid}, 8'h00);

        // Simultaneous push and pop at count 2
        push(8'h41);
        push(8'h42);
        rx_valid = 1'b1;
        rx_data  = 8'h43;
        rd(2'd0, 8'hC1, "pushpop_head");
        rx_valid = 1'b0;
        rd(2'd0, 8'hC2, "pushpop_second");
        rd(2'd0, 8'hC3, "pushpop_third");
        rd(2'd1, 8'h7F, "pushpop_count2");

        // Asynchronous reset mid-operation
        push(8'h31);
        push(8'h32);
        push(8'h33);
        wr(2'd2, 8'h55);
        chk("pre_rst_tx_valid", {7'd0, tx_valid}, 8'h01);
        address = 2'd1;
        #1;
        chk("pre_rst_kbdcr", dout, 8'hFF);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tx_valid", {7'd0, tx_valid}, 8'h00);
        chk("arst_tx_data", tx_data, 8'h00);
        chk("arst_rx_ready", {7'd0, rx_ready}, 8'h01);
        chk("arst_kbdcr", dout, 8'h00);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        rd(2'd0, 8'h80, "post_rst_kbd");
        rd(2'd1, 8'h00, "post_rst_kbdcr");
        rd(2'd3, 8'h00, "post_rst_dspcr");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
